pool2_ofm_writer: RTL and testbench

Output-side collector for the second pooling stage. It captures the three per-unit pooled results on every valid strobe from the pooling controller and generates write addresses for the next-stage IFM memory. It walks all output-map groups (passes) of one layer without re-start. It asserts per-lane write enables, masks lanes that fall beyond the last map, and reports pass and layer completion.

---
 rtl/pool2_ofm_writer.sv | 178 +++++++++++++++++
 tb/tb_pool2_ofm_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pool2_ofm_writer.sv
// pool2_ofm_writer
//   Collects the three pooled results of the second pooling stage on each
//   data_valid strobe and turns them into registered write transactions for
//   the next-stage IFM memory. Walks every map group (pass) of one layer
//   after a single start. Lanes that would address a map beyond IFM_DEPTH
//   are masked off.
//
// Ports
//   clk                     rising-edge clock
//   reset                   synchronous, active-high
//   start                   one-cycle pulse, begins a layer (IDLE only)
//   data_valid              data_in_1..3 are valid this cycle
//   data_in_1..3            pooled samples from units 1..3
//   wr_en_1..3              per-lane memory write enable
//   wr_addr                 row-major pixel address inside the map
//   map_base                map index of lane 1 (lane k writes map_base+k-1)
//   data_out_1..3           registered write data
//   pass_done               pulses together with the write of the last pixel of a pass
//   done                    pulses the cycle after the last write of the layer
//   busy                    high from the cycle after start until done
module pool2_ofm_writer #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 14,
    parameter int IFM_DEPTH             = 16,
    parameter int KERNAL_SIZE           = 2,
    parameter int NUMBER_OF_UNITS       = 3,
    parameter int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / 2 + 1,
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int NUMBER_OF_PASSES      = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
    parameter int MAP_INDEX_SIZE        = $clog2(IFM_DEPTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             data_valid,
    input  logic [DATA_WIDTH-1:0]            data_in_1,
    input  logic [DATA_WIDTH-1:0]            data_in_2,
    input  logic [DATA_WIDTH-1:0]            data_in_3,
    output logic                             wr_en_1,
    output logic                             wr_en_2,
    output logic                             wr_en_3,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr,
    output logic [MAP_INDEX_SIZE-1:0]        map_base,
    output logic [DATA_WIDTH-1:0]            data_out_1,
    output logic [DATA_WIDTH-1:0]            data_out_2,
    output logic [DATA_WIDTH-1:0]            data_out_3,
    output logic                             pass_done,
    output logic                             done,
    output logic                             busy
);

    localparam int PIX_LAST = IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1;
    localparam int PASS_W   = (NUMBER_OF_PASSES > 1) ? $clog2(NUMBER_OF_PASSES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FINISH
    } state_t;

    state_t                           r_state;
    state_t                           w_next;

    logic [ADDRESS_SIZE_NEXT_IFM-1:0] r_pix;
    logic [PASS_W-1:0]                r_pass;

    logic [2:0]                       r_wr_en;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] r_wr_addr;
    logic [MAP_INDEX_SIZE-1:0]        r_map_base;
    logic [DATA_WIDTH-1:0]            r_data_1;
    logic [DATA_WIDTH-1:0]            r_data_2;
    logic [DATA_WIDTH-1:0]            r_data_3;
    logic                             r_pass_done;
    logic                             r_done;
    logic                             r_busy;

    logic                             w_start;
    logic                             w_write;
    logic                             w_pix_last;
    logic                             w_pass_last;
    logic [31:0]                      w_map_full;
    logic [2:0]                       w_lane_en;

    // Start is refused during the done pulse, so the earliest accepted
    // restart is the cycle after done.
    assign w_start     = (r_state == IDLE) && start && !r_done;
    assign w_write     = (r_state == WRITE) && data_valid;
    assign w_pix_last  = (r_pix == ADDRESS_SIZE_NEXT_IFM'(PIX_LAST));
    assign w_pass_last = (r_pass == PASS_W'(NUMBER_OF_PASSES - 1));

    always_comb begin
        w_map_full = 32'(r_pass) * 32'(NUMBER_OF_UNITS);
        w_lane_en  = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            w_lane_en[k] = (w_map_full + k) < 32'(IFM_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = WRITE;
            WRITE:   if (w_write && w_pix_last && w_pass_last) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix       <= '0;
            r_pass      <= '0;
            r_wr_en     <= '0;
            r_wr_addr   <= '0;
            r_map_base  <= '0;
            r_data_1    <= '0;
            r_data_2    <= '0;
            r_data_3    <= '0;
            r_pass_done <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en     <= '0;
            r_pass_done <= 1'b0;
            r_done      <= 1'b0;

            if (w_start) begin
                r_pix  <= '0;
                r_pass <= '0;
                r_busy <= 1'b1;
            end

            if (w_write) begin
                r_data_1    <= data_in_1;
                r_data_2    <= data_in_2;
                r_data_3    <= data_in_3;
                r_wr_addr   <= r_pix;
                r_map_base  <= MAP_INDEX_SIZE'(w_map_full);
                r_wr_en     <= w_lane_en;
                r_pass_done <= w_pix_last;
                if (w_pix_last) begin
                    r_pix  <= '0;
                    r_pass <= w_pass_last ? '0 : r_pass + 1'b1;
                end else begin
                    r_pix <= r_pix + 1'b1;
                end
            end

            // FINISH is entered with the final write on the outputs, so done
            // lands one cycle after that write and busy drops with it.
            if (r_state == FINISH) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign wr_en_1    = r_wr_en[0];
    assign wr_en_2    = r_wr_en[1];
    assign wr_en_3    = r_wr_en[2];
    assign wr_addr    = r_wr_addr;
    assign map_base   = r_map_base;
    assign data_out_1 = r_data_1;
    assign data_out_2 = r_data_2;
    assign data_out_3 = r_data_3;
    assign pass_done  = r_pass_done;
    assign done       = r_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_pool2_ofm_writer.sv
// tb_pool2_ofm_writer
//   Directed self-checking bench for pool2_ofm_writer with default geometry
//   (7x7 output maps, 16 maps, 3 lanes -> 6 passes, 294 writes per layer).
module tb_pool2_ofm_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        data_valid;
    logic [31:0] data_in_1;
    logic [31:0] data_in_2;
    logic [31:0] data_in_3;
    logic        wr_en_1;
    logic        wr_en_2;
    logic        wr_en_3;
    logic [5:0]  wr_addr;
    logic [3:0]  map_base;
    logic [31:0] data_out_1;
    logic [31:0] data_out_2;
    logic [31:0] data_out_3;
    logic        pass_done;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pool2_ofm_writer #(
        .DATA_WIDTH     (32),
        .IFM_SIZE       (14),
        .IFM_DEPTH      (16),
        .KERNAL_SIZE    (2),
        .NUMBER_OF_UNITS(3)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_valid(data_valid),
        .data_in_1 (data_in_1),
        .data_in_2 (data_in_2),
        .data_in_3 (data_in_3),
        .wr_en_1   (wr_en_1),
        .wr_en_2   (wr_en_2),
        .wr_en_3   (wr_en_3),
        .wr_addr   (wr_addr),
        .map_base  (map_base),
        .data_out_1(data_out_1),
        .data_out_2(data_out_2),
        .data_out_3(data_out_3),
        .pass_done (pass_done),
        .done      (done),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after a falling edge, then wait for the next falling
    // edge so the outputs registered at the rising edge in between are stable.
    task automatic step(input logic st, input logic v, input logic [31:0] d1);
        start      = st;
        data_valid = v;
        data_in_1  = d1;
        data_in_2  = d1 + 32'd100;
        data_in_3  = d1 + 32'd200;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},   {29'd0, wr_en_3, wr_en_2, wr_en_1}, 32'd0);
        check({tag, "_addr"}, {26'd0, wr_addr}, 32'd0);
        check({tag, "_map"},  {28'd0, map_base}, 32'd0);
        check({tag, "_d1"},   data_out_1, 32'd0);
        check({tag, "_d2"},   data_out_2, 32'd0);
        check({tag, "_d3"},   data_out_3, 32'd0);
        check({tag, "_flags"}, {29'd0, pass_done, done, busy}, 32'd0);
    endtask

    // One layer: start (optionally with a coincident valid), then 6x49 writes.
    // abort_pass/abort_px stop the layer before that pixel is written.
    task automatic run_layer(input bit gapped, input bit coincide, input bit mid_start,
                             input int abort_pass, input int abort_px);
        int          writes;
        int          pdones;
        logic [31:0] d1;
        logic [2:0]  exp_en;
        logic        st;
        writes = 0;
        pdones = 0;
        step(1'b1, coincide, 32'hDEAD_0000);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_nowr", {29'd0, wr_en_3, wr_en_2, wr_en_1}, 32'd0);
        for (int p = 0; p < 6; p++) begin
            for (int px = 0; px < 49; px++) begin
                if (p == abort_pass && px == abort_px) return;
                if (gapped) begin
                    repeat ($urandom_range(0, 2)) begin
                        step(1'b0, 1'b0, 32'hBAD0_0000);
                        check("gap_en", {29'd0, wr_en_3, wr_en_2, wr_en_1}, 32'd0);
                        check("gap_pd", {31'd0, pass_done}, 32'd0);
                        check("gap_busy", {31'd0, busy}, 32'd1);
                        if (writes > 0) begin
                            check("gap_addr_hold", {26'd0, wr_addr}, 32'(px == 0 ? 48 : px - 1));
                            check("gap_data_hold", data_out_1, (32'(p) << 16) + 32'(px) - 32'd1 -
                                  ((px == 0) ? 32'h0000_FFCF : 32'd0));
                        end
                    end
                end
                st = mid_start && p == 0 && px == 20;
                d1 = (32'(p) << 16) | 32'(px);
                step(st, 1'b1, d1);
                writes++;
                exp_en = (p < 5) ? 3'b111 : 3'b001;
                check("wr_en",    {29'd0, wr_en_3, wr_en_2, wr_en_1}, {29'd0, exp_en});
                check("wr_addr",  {26'd0, wr_addr}, 32'(px));
                check("map_base", {28'd0, map_base}, 32'(p * 3));
                check("data1",    data_out_1, d1);
                check("data2",    data_out_2, d1 + 32'd100);
                check("data3",    data_out_3, d1 + 32'd200);
                check("pass_done", {31'd0, pass_done}, {31'd0, px == 48});
                check("wr_done",  {31'd0, done}, 32'd0);
                check("wr_busy",  {31'd0, busy}, 32'd1);
                if (pass_done) pdones++;
            end
        end
        check("writes", 32'(writes), 32'd294);
        check("pass_done_cnt", 32'(pdones), 32'd6);
        step(1'b0, 1'b0, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_en", {29'd0, wr_en_3, wr_en_2, wr_en_1}, 32'd0);
        step(1'b0, 1'b1, 32'd0);
        check("done_once", {31'd0, done}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("post_idle_en", {29'd0, wr_en_3, wr_en_2, wr_en_1}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in_1  = '0;
        data_in_2  = '0;
        data_in_3  = '0;
        @(negedge clk);

        // Reset held two cycles with data_valid toggling.
        step(1'b0, 1'b1, 32'h1111);
        check_all_zero("rst1");
        step(1'b0, 1'b0, 32'h2222);
        check_all_zero("rst2");
        reset = 1'b0;

        // Valids in IDLE are ignored.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, i[0], 32'h3000 + 32'(i));
            check_all_zero("idle_valid");
        end

        // Back-to-back layer: coincident valid on start, stray start at pixel 20.
        run_layer(1'b0, 1'b1, 1'b1, -1, -1);

        // Gapped layer.
        run_layer(1'b1, 1'b0, 1'b0, -1, -1);

        // Reset in pass 2, pixel 30, with a valid presented alongside.
        run_layer(1'b0, 1'b0, 1'b0, 2, 30);
        reset = 1'b1;
        step(1'b0, 1'b1, 32'h0002_001E);
        check_all_zero("midrst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h4000);
            check_all_zero("after_rst");
        end

        // Fresh layer restarts at map_base 0, wr_addr 0.
        run_layer(1'b0, 1'b0, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
